// File: rtl/mux_nto1_scan.sv
// -----------------------------------------------------------------------------
// mux_nto1_scan
//
// Registered N-channel multiplexer with two select sources. In manual mode it
// uses sel_in. In scan mode an internal sequencer stays on each channel for
// DWELL cycles. Every output is registered. ch_out tags the channel that the
// sample in y_out came from.
//
// Ports
//   clk_in     in   1            clock, rising edge
//   rst_n_in   in   1            asynchronous active-low reset
//   d_in       in   NUM_CH*D_W   channel k at d_in[k*D_W +: D_W]
//   sel_in     in   SEL_W        manual channel select
//   mode_in    in   1            0 = manual, 1 = scan
//   en_in      in   1            1 = update, 0 = freeze all state
//   y_out      out  D_W          registered sample of the selected channel
//   ch_out     out  SEL_W        channel index y_out was taken from
//   valid_out  out  1            y_out/ch_out were updated on this edge
//   wrap_out   out  1            one-cycle pulse when the scan wraps to ch 0
// -----------------------------------------------------------------------------
module mux_nto1_scan #(
    parameter  int NUM_CH = 4,
    parameter  int D_W    = 1,
    parameter  int DWELL  = 5,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic [NUM_CH*D_W-1:0]  d_in,
    input  logic [SEL_W-1:0]       sel_in,
    input  logic                   mode_in,
    input  logic                   en_in,
    output logic [D_W-1:0]         y_out,
    output logic [SEL_W-1:0]       ch_out,
    output logic                   valid_out,
    output logic                   wrap_out
);

    localparam int                CNT_W      = $clog2(DWELL + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0]  CH_LAST    = SEL_W'(NUM_CH - 1);
    localparam logic [SEL_W:0]    NUM_CH_EXT = (SEL_W + 1)'(NUM_CH);

    // ST_MANUAL     : last enabled edge was manual, so the dwell counter is 0.
    // ST_SCAN_DWELL : scanning, and the next scan edge only counts.
    // ST_SCAN_STEP  : scanning, and the next scan edge advances the channel.
    typedef enum logic [1:0] {
        ST_MANUAL,
        ST_SCAN_DWELL,
        ST_SCAN_STEP
    } state_t;

    state_t            state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [SEL_W-1:0]  ch_q,     ch_d;
    logic [D_W-1:0]    y_q,      y_d;
    logic [SEL_W-1:0]  ch_out_q, ch_out_d;
    logic              valid_q,  valid_d;
    logic              wrap_q,   wrap_d;

    logic [D_W-1:0]    chan [NUM_CH];
    logic              sel_ok;
    logic              step;
    logic [SEL_W-1:0]  ch_inc;
    logic [CNT_W-1:0]  cnt_inc;

    // Unpack the flat input bus into one entry per channel.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            assign chan[gi] = d_in[gi*D_W +: D_W];
        end
    endgenerate

    // sel_in codes at or above NUM_CH exist only when NUM_CH is not a power of two.
    assign sel_ok  = ({1'b0, sel_in} < NUM_CH_EXT);

    // The channel wraps at NUM_CH. It does not wrap at 2**SEL_W.
    assign ch_inc  = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
    assign cnt_inc = cnt_q + 1'b1;

    // Coming from manual, the counter is 0. That edge is a step edge only when DWELL is 1.
    assign step = (state_q == ST_SCAN_STEP) ||
                  ((state_q == ST_MANUAL) && (CNT_LAST == '0));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ch_d     = ch_q;
        y_d      = y_q;
        ch_out_d = ch_out_q;
        valid_d  = 1'b0;
        wrap_d   = 1'b0;

        if (en_in) begin
            if (!mode_in) begin
                state_d = ST_MANUAL;
                cnt_d   = '0;
                if (sel_ok) begin
                    ch_d     = sel_in;
                    y_d      = chan[sel_in];
                    ch_out_d = sel_in;
                    valid_d  = 1'b1;
                end
            end else begin
                // The sample comes from the channel in use at this edge. The advance takes effect after it.
                y_d      = chan[ch_q];
                ch_out_d = ch_q;
                valid_d  = 1'b1;
                if (step) begin
                    cnt_d   = '0;
                    ch_d    = ch_inc;
                    wrap_d  = (ch_q == CH_LAST);
                    state_d = (CNT_LAST == '0) ? ST_SCAN_STEP : ST_SCAN_DWELL;
                end else begin
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == CNT_LAST) ? ST_SCAN_STEP : ST_SCAN_DWELL;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= ST_MANUAL;
            cnt_q    <= '0;
            ch_q     <= '0;
            y_q      <= '0;
            ch_out_q <= '0;
            valid_q  <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ch_q     <= ch_d;
            y_q      <= y_d;
            ch_out_q <= ch_out_d;
            valid_q  <= valid_d;
            wrap_q   <= wrap_d;
        end
    end

    assign y_out     = y_q;
    assign ch_out    = ch_out_q;
    assign valid_out = valid_q;
    assign wrap_out  = wrap_q;

endmodule
